servo_capture: RTL
==================

SERVO_CAPTURE -- requirements
Module: servo_capture

Interface
REQ-001 SHALL have parameter PRESCALE, default 50, meaning clk cycles per measurement tick.
REQ-002 SHALL have parameter PERIOD, default 10000, meaning ticks without a rising edge before a channel is declared lost.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port servo_in  input  2  asynchronous pulse inputs, bit n = channel n.
REQ-006 SHALL have port out_data  output  24  {width1, width0}, 12 bits each, in ticks.
REQ-007 SHALL have port out_new  output  2  sticky per-channel "fresh capture since last read" flags.
REQ-008 SHALL have port out_lost  output  2  per-channel signal-lost flags.
REQ-009 SHALL have port out_rd  input  1  read strobe; clears out_new.

Function
REQ-010 SHALL pass each servo_in bit through a 2-flop synchronizer, then a third flop for edge detection; edges are acted on 3 clk after the pin changes.
REQ-011 SHALL use one shared prescaler counting 0..PRESCALE-1, asserting tick for one clk when at PRESCALE-1, then wrapping to 0.
REQ-012 SHALL run per channel an FSM with states WAIT_LOW, WAIT_RISE and MEASURE.
REQ-013 WAIT_LOW: synchronized input low -> WAIT_RISE; no capture is made from a pulse already high at entry.
REQ-014 WAIT_RISE: rising edge -> MEASURE, width counter cleared to 0, timeout counter cleared to 0.
REQ-015 MEASURE: width counter +1 per tick, saturating at 4095 with no wrap.
REQ-016 MEASURE, falling edge: latch width counter into widthN, set out_new[N]=1, clear out_lost[N], go to WAIT_RISE.
REQ-017 Timeout counter: 14 bits, +1 per tick in WAIT_RISE and MEASURE, saturating, cleared only on rising edge.
REQ-018 Timeout counter reaching PERIOD: set out_lost[N]=1, set widthN=0, leave out_new[N] unchanged, go to WAIT_LOW.
REQ-019 out_rd=1 SHALL clear both out_new bits on the next clk.
REQ-020 A capture and out_rd in the same cycle: the capture wins, so that out_new bit reads 1 afterwards.
REQ-021 Captured width accuracy: high time in ticks, within -0/+1 tick of (high clk cycles / PRESCALE).
REQ-022 Channels SHALL be fully independent; simultaneous events on both channels are each handled in the same cycle.
REQ-023 out_data SHALL change only on capture or timeout and SHALL remain stable otherwise.

Reset
REQ-024 While rst=1: prescaler=0, all FSMs=WAIT_LOW, width/timeout counters=0, out_data=24'h000000, out_new=2'b00, out_lost=2'b00, synchronizer flops=0.
REQ-025 Deassertion of rst mid-pulse SHALL discard that pulse, per REQ-013.

Verification
REQ-026 Width capture: PRESCALE=50, ch0 high for 75000 clk -> out_data[11:0] in {1500, 1501}, out_new=2'b01; then out_rd -> out_new=2'b00.
REQ-027 Saturation and independence: ch1 high for 5000 ticks -> out_data[23:12]=4095, ch0 fields and flags unchanged.
REQ-028 Timeout: valid ch0 capture, then input held low for 10000 ticks -> out_lost[0]=1, out_data[11:0]=0; next valid pulse -> out_lost[0]=0.
REQ-029 Reset mid-pulse: rst released with ch0 high, low after 800 ticks -> no capture; next 1000-tick pulse -> width 1000 or 1001.
REQ-030 Read collision: out_rd asserted in the same clk as a ch0 falling-edge capture -> out_new[0]=1 after that clk.

Source files
------------

// File: rtl/servo_capture_if.sv
// Bundle of the servo capture pins: the two pulse inputs, the read strobe and the
// captured width / status outputs. The DUT connects through the slave modport and
// whatever drives the pulses and consumes the results uses the master modport.
//   servo_in [1:0]  : asynchronous pulse inputs, bit n = channel n
//   out_rd          : read strobe, clears out_new
//   out_data [23:0] : {width1, width0}, 12 bits each, in ticks
//   out_new  [1:0]  : sticky "fresh capture since last read" flags
//   out_lost [1:0]  : per-channel signal-lost flags
interface servo_capture_if;
  logic [1:0]  servo_in;
  logic        out_rd;
  logic [23:0] out_data;
  logic [1:0]  out_new;
  logic [1:0]  out_lost;

  modport master (
    output servo_in,
    output out_rd,
    input  out_data,
    input  out_new,
    input  out_lost
  );

  modport slave (
    input  servo_in,
    input  out_rd,
    output out_data,
    output out_new,
    output out_lost
  );
endinterface

// File: rtl/servo_capture.sv
// Two-channel servo pulse width capture.
// Each pulse input is synchronized, edge-detected and measured in ticks of a shared
// prescaler. A falling edge latches the width and raises out_new; going PERIOD ticks
// without a rising edge raises out_lost and zeroes that channel's width.
//   clk : single clock, all logic on posedge
//   rst : asynchronous active-high reset
//   bus : servo_capture_if slave (servo_in, out_rd in; out_data, out_new, out_lost out)
module servo_capture #(
  parameter int unsigned PRESCALE = 50,    // clk cycles per measurement tick
  parameter int unsigned PERIOD   = 10000  // ticks without a rising edge before loss
) (
  input logic             clk,
  input logic             rst,
  servo_capture_if.slave  bus
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);
  localparam logic [13:0] ToLast = 14'(PERIOD - 1);

  localparam logic [1:0] StWaitLow  = 2'd0;
  localparam logic [1:0] StWaitRise = 2'd1;
  localparam logic [1:0] StMeasure  = 2'd2;

  logic [PsW-1:0]  ps_q, ps_d;
  logic            tick;

  logic [1:0]      s1_q, s2_q, s3_q;
  logic [1:0]      vld_q, vld_d;
  logic            sync_rdy;
  logic [1:0]      rise, fall;

  logic [1:0][1:0]  state_q, state_d;
  logic [1:0][11:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0][13:0] to_q, to_d, to_inc;
  logic [1:0]       to_hit;
  logic [1:0][11:0] width_q, width_d;
  logic [1:0]       new_q, new_d;
  logic [1:0]       lost_q, lost_d;

  // Marks when the synchronizer holds real pin samples rather than reset zeros, so a
  // pulse already high when reset is released is not mistaken for a low level.
  assign vld_d    = {vld_q[0], 1'b1};
  assign sync_rdy = vld_q[1];

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    tick = (ps_q == PsMax);
    ps_d = tick ? '0 : ps_q + PsW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    width_d = width_q;
    lost_d  = lost_q;
    // A capture later in this block overrides the read clear.
    new_d   = bus.out_rd ? 2'b00 : new_q;
    cnt_inc = cnt_q;
    to_inc  = to_q;
    to_hit  = 2'b00;

    for (int c = 0; c < 2; c++) begin
      cnt_inc[c] = (tick && cnt_q[c] != 12'hFFF) ? cnt_q[c] + 12'd1 : cnt_q[c];
      to_inc[c]  = (tick && to_q[c] != 14'h3FFF) ? to_q[c] + 14'd1 : to_q[c];
      // Fires once, on the tick that brings the count to PERIOD; the counter keeps
      // saturating past it so a lost channel does not retrigger.
      to_hit[c]  = tick && (to_q[c] == ToLast);

      case (state_q[c])
        StWaitLow: begin
          if (sync_rdy && !s2_q[c]) begin
            state_d[c] = StWaitRise;
          end
        end
        StWaitRise: begin
          if (rise[c]) begin
            state_d[c] = StMeasure;
            cnt_d[c]   = '0;
            to_d[c]    = '0;
          end else if (to_hit[c]) begin
            to_d[c]    = to_inc[c];
            lost_d[c]  = 1'b1;
            width_d[c] = '0;
            state_d[c] = StWaitLow;
          end else begin
            to_d[c] = to_inc[c];
          end
        end
        StMeasure: begin
          cnt_d[c] = cnt_inc[c];
          to_d[c]  = to_inc[c];
          if (fall[c]) begin
            // Include this cycle's tick so the width covers the full high time.
            width_d[c] = cnt_inc[c];
            new_d[c]   = 1'b1;
            lost_d[c]  = 1'b0;
            state_d[c] = StWaitRise;
          end else if (to_hit[c]) begin
            lost_d[c]  = 1'b1;
            width_d[c] = '0;
            state_d[c] = StWaitLow;
          end
        end
        default: state_d[c] = StWaitLow;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      vld_q   <= '0;
      state_q <= {StWaitLow, StWaitLow};
      cnt_q   <= '0;
      to_q    <= '0;
      width_q <= '0;
      new_q   <= '0;
      lost_q  <= '0;
    end else begin
      ps_q    <= ps_d;
      s1_q    <= bus.servo_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vld_q   <= vld_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      width_q <= width_d;
      new_q   <= new_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.out_data = {width_q[1], width_q[0]};
  assign bus.out_new  = new_q;
  assign bus.out_lost = lost_q;

endmodule
